inst_fetch: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the arithmetic/decode datapath. Owns the PC, issues

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fifo.sv | 63 ++++++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state encoding,
// reset PC default, PC step and the FIFO entry layout.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read channel plus the instruction valid/ready channel of the fetch stage.
// master = fetch stage, slave = memory/consumer side.
interface inst_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fifo.sv
// Prefetch FIFO of {pc, inst} entries with push/pop/flush; flush wins over both.
// The head output holds its last value while empty so consumers never see X.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [CW-1:0] o_count,
  output logic         o_valid,
  output fetch_entry_t o_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_last;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_valid   = (r_count != '0);
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & o_valid & ~i_flush;

  // NOTE: the storage array is deliberately not reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (o_valid) r_last <= r_mem[r_rd_ptr];
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
    end
  end

  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, req/ack fetch FSM and prefetch FIFO with redirect flush.
// Optional INST_FETCH_STALL_CNT_EN adds a saturating count of cycles with no valid instruction.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  inst_fetch_if.master bus,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc
`ifdef INST_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]  stall_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_drop_addr;
  logic [31:0]   w_drop_addr_nxt;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_addr;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_level_after;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  assign w_redirect_pc = word_align(redirect_pc);
  assign w_pop         = w_valid & bus.inst_ready;
  assign w_push_data   = '{pc: r_pc, inst: bus.imem_rdata};
  // Occupancy after an ack in this cycle; the outstanding slot was already reserved.
  assign w_level_after = w_count + CW'(1) - CW'(w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= word_align(RESET_PC);
      r_drop_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_req           = 1'b0;
    w_addr          = r_pc;
    w_push          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
        end else if (w_count < CW'(DEPTH)) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (bus.imem_ack) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt     = ST_DROP;
            w_drop_addr_nxt = r_pc;
          end
        end else if (bus.imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = next_pc(r_pc);
          w_state_nxt = (w_level_after < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        // The abandoned read must complete on its original address; its data is discarded.
        w_req  = 1'b1;
        w_addr = r_drop_addr;
        if (redirect)     w_pc_nxt    = w_redirect_pc;
        if (bus.imem_ack) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_data  (w_head)
  );

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = w_addr;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

`ifdef INST_FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (!w_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run scored
// against a PC-sequence model and a memory model that returns a fixed function of the address.
module tb_inst_fetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef INST_FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  inst_fetch_if bus();

  inst_fetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef INST_FETCH_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; logic [31:0] addr; } ack_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] inst; } pop_t;

  int errors = 0;
  int checks = 0;

  int          cyc;
  int          ack_mode;    // 1: ack after ack_wait req-high cycles, 2: every 3rd cycle, 3: random
  int          ack_wait;
  int          ready_mode;  // 0: low, 1: high, 2: random
  bit          redir_req;
  bit          last_redir;
  logic [31:0] redir_tgt;
  int          req_hi_cnt;
  int          viol;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;
  ack_t        ack_log[$];
  pop_t        pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock cycle: sample outputs mid-cycle, act as memory and consumer, log what the next edge commits.
  task automatic cycle();
    logic ack, rdy;
    ack_t a;
    pop_t p;
    @(negedge clock);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.inst_valid;
    s_inst  = bus.inst;
    s_pc    = bus.inst_pc;
    if (s_req && prev_req && !prev_ack && (s_addr !== prev_addr)) viol++;
    if (s_req && (s_addr[1:0] !== 2'b00)) viol++;
    ack = 1'b0;
    if (s_req) begin
      case (ack_mode)
        1:       ack = (req_hi_cnt >= ack_wait);
        2:       ack = ((cyc % 3) == 0);
        default: ack = ($urandom_range(99) < 40);
      endcase
    end else if (ack_mode == 3) begin
      ack = ($urandom_range(1) == 1);
    end
    req_hi_cnt = (s_req && !ack) ? req_hi_cnt + 1 : 0;
    rdy = (ready_mode == 2) ? ($urandom_range(1) == 1) : (ready_mode == 1);
    bus.imem_ack   = ack;
    bus.imem_rdata = (s_req && ack) ? mem_word(s_addr) : $urandom();
    bus.inst_ready = rdy;
    redirect       = redir_req;
    redirect_pc    = redir_req ? redir_tgt : $urandom();
    last_redir     = redir_req;
    redir_req      = 1'b0;
    if (s_req && ack) begin
      a.cyc = cyc; a.addr = s_addr;
      ack_log.push_back(a);
    end
    if (s_valid && rdy && !last_redir) begin
      p.cyc = cyc; p.pc = s_pc; p.inst = s_inst;
      pop_log.push_back(p);
    end
    prev_req  = s_req;
    prev_ack  = ack;
    prev_addr = s_addr;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clock);
    reset      = 1'b1;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = '0;
    req_hi_cnt = 0;
    redir_req  = 1'b0;
    viol       = 0;
    cyc        = 0;
    ack_log.delete();
    pop_log.delete();
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    bus.inst_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(negedge clock);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", bus.inst_pc); end
`ifdef INST_FETCH_STALL_CNT_EN
    checks++; if (stall_count !== 32'h0) begin errors++; $display("FAIL reset_stall_count: got %h expected 0", stall_count); end
`endif
  endtask

  task automatic test_stream();
    int first_valid = -1;
    do_reset();
    ack_mode = 1; ack_wait = 0; ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_valid && first_valid < 0) first_valid = cyc - 1;
    end
    checks++;
    if (ack_log.size() == 0 || ack_log[0].addr !== RST_PC) begin
      errors++; $display("FAIL stream_first_addr: got %h expected %h",
                         (ack_log.size() > 0) ? ack_log[0].addr : 32'hDEAD_BEEF, RST_PC);
    end
    checks++;
    if (ack_log.size() == 0 || first_valid != ack_log[0].cyc + 1) begin
      errors++; $display("FAIL stream_latency: valid at cycle %0d expected %0d", first_valid,
                         (ack_log.size() > 0) ? ack_log[0].cyc + 1 : -1);
    end
    checks++; if (pop_log.size() != 11) begin errors++; $display("FAIL stream_pop_count: got %0d expected 11", pop_log.size()); end
    for (int k = 0; k < ack_log.size(); k++) begin
      checks++;
      if (ack_log[k].addr !== RST_PC + 32'(4 * k)) begin
        errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, ack_log[k].addr, RST_PC + 32'(4 * k));
      end
    end
    for (int k = 0; k < pop_log.size(); k++) begin
      checks++;
      if (pop_log[k].pc !== RST_PC + 32'(4 * k) || pop_log[k].inst !== mem_word(RST_PC + 32'(4 * k))) begin
        errors++; $display("FAIL stream_pop[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", k, pop_log[k].pc,
                           pop_log[k].inst, RST_PC + 32'(4 * k), mem_word(RST_PC + 32'(4 * k)));
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stream_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_mode = 1; ack_wait = 0; ready_mode = 0;
    repeat (10) cycle();
    checks++; if (ack_log.size() != DEPTH) begin errors++; $display("FAIL bp_fetched: got %0d expected %0d", ack_log.size(), DEPTH); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b expected 0", s_req); end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== RST_PC || s_inst !== mem_word(RST_PC)) begin
      errors++; $display("FAIL bp_head: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         s_valid, s_pc, s_inst, RST_PC, mem_word(RST_PC));
    end
    ready_mode = 1;
    repeat (16) cycle();
    checks++; if (pop_log.size() != 16) begin errors++; $display("FAIL bp_resume_count: got %0d expected 16", pop_log.size()); end
    for (int k = 0; k < pop_log.size(); k++) begin
      checks++;
      if (pop_log[k].pc !== RST_PC + 32'(4 * k) || pop_log[k].inst !== mem_word(RST_PC + 32'(4 * k))) begin
        errors++; $display("FAIL bp_order[%0d]: got pc=%h expected pc=%h", k, pop_log[k].pc, RST_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_latency();
    int budget = 10;
    int stale = 0;
    do_reset();
    ack_mode = 1; ack_wait = 3; ready_mode = 1;
    do begin cycle(); budget--; end while (!s_req && budget > 0);
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL redir_lat_req: got %b expected 1 within budget", s_req); end
    redir_req = 1'b1; redir_tgt = 32'h0040_0103;
    cycle();
    repeat (20) cycle();
    checks++;
    if (ack_log.size() < 2 || ack_log[0].addr !== RST_PC || ack_log[1].addr !== 32'h0040_0100) begin
      errors++; $display("FAIL redir_lat_addrs: got n=%0d a0=%h a1=%h expected a0=%h a1=00400100", ack_log.size(),
                         (ack_log.size() > 0) ? ack_log[0].addr : 32'hDEAD_BEEF,
                         (ack_log.size() > 1) ? ack_log[1].addr : 32'hDEAD_BEEF, RST_PC);
    end
    checks++;
    if (pop_log.size() == 0 || pop_log[0].pc !== 32'h0040_0100 || pop_log[0].inst !== mem_word(32'h0040_0100)) begin
      errors++; $display("FAIL redir_lat_first_pop: got pc=%h expected 00400100",
                         (pop_log.size() > 0) ? pop_log[0].pc : 32'hDEAD_BEEF);
    end
    foreach (pop_log[k]) if (pop_log[k].pc == RST_PC) stale++;
    checks++; if (stale != 0) begin errors++; $display("FAIL redir_lat_stale: got %0d stale words expected 0", stale); end
    checks++; if (viol != 0) begin errors++; $display("FAIL redir_lat_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_redirect_with_ack();
    int stale = 0;
    do_reset();
    ack_mode = 1; ack_wait = 0; ready_mode = 0;
    repeat (2) cycle();
    redir_req = 1'b1; redir_tgt = 32'h0040_0800;
    cycle();
    checks++; if (ack_log.size() != 3) begin errors++; $display("FAIL redir_ack_same_cycle: got %0d acks expected 3", ack_log.size()); end
    cycle();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL redir_ack_flush: got valid=%b expected 0", s_valid); end
    checks++;
    if (s_pc !== RST_PC || s_inst !== mem_word(RST_PC)) begin
      errors++; $display("FAIL redir_ack_hold: got pc=%h inst=%h expected pc=%h inst=%h", s_pc, s_inst, RST_PC, mem_word(RST_PC));
    end
    ready_mode = 1;
    repeat (15) cycle();
    checks++;
    if (pop_log.size() == 0 || pop_log[0].pc !== 32'h0040_0800) begin
      errors++; $display("FAIL redir_ack_first_pop: got pc=%h expected 00400800",
                         (pop_log.size() > 0) ? pop_log[0].pc : 32'hDEAD_BEEF);
    end
    foreach (pop_log[k]) if (pop_log[k].pc < 32'h0040_0800) stale++;
    checks++; if (stale != 0) begin errors++; $display("FAIL redir_ack_stale: got %0d stale words expected 0", stale); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    do_reset();
    ack_mode = 1; ack_wait = 0; ready_mode = 1;
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    cycle();
    ack_log.delete(); pop_log.delete();
    repeat (8) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack_log.size() <= k || ack_log[k].addr !== exp_a[k]) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k,
                           (ack_log.size() > k) ? ack_log[k].addr : 32'hDEAD_BEEF, exp_a[k]);
      end
      checks++;
      if (pop_log.size() <= k || pop_log[k].pc !== exp_a[k] || pop_log[k].inst !== mem_word(exp_a[k])) begin
        errors++; $display("FAIL wrap_pop[%0d]: got pc=%h expected %h", k,
                           (pop_log.size() > k) ? pop_log[k].pc : 32'hDEAD_BEEF, exp_a[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ack_mode = 1; ack_wait = 5; ready_mode = 1;
    repeat (2) cycle();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL async_pending: got req=%b expected 1", s_req); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: got %b expected 0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", bus.inst_valid); end
  endtask

`ifdef INST_FETCH_STALL_CNT_EN
  task automatic test_stall_count();
    int exp_stall = 1;
    do_reset();
    ack_mode = 2; ready_mode = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (stall_count !== 32'(exp_stall)) begin
        errors++; $display("FAIL stall_count[%0d]: got %0d expected %0d", i, stall_count, exp_stall);
      end
      if (!s_valid) exp_stall++;
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc = RST_PC;
    int          pops = 0;
    pop_t        p;
    do_reset();
    ack_mode = 3; ready_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_req = 1'b1;
        redir_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      end
      cycle();
      while (pop_log.size() > 0) begin
        p = pop_log.pop_front();
        pops++;
        checks++;
        if (p.pc !== exp_pc || p.inst !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rand_pop@%0d: got pc=%h inst=%h expected pc=%h inst=%h", p.cyc, p.pc, p.inst,
                             exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (last_redir) exp_pc = redir_tgt & ~32'h3;
    end
    checks++; if (pops < 80) begin errors++; $display("FAIL rand_progress: got %0d pops expected at least 80", pops); end
    checks++; if (viol != 0) begin errors++; $display("FAIL rand_protocol: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_with_ack();
    test_pc_wrap();
    test_async_reset();
`ifdef INST_FETCH_STALL_CNT_EN
    test_stall_count();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
